// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-requester round-robin arbiter and read-return sequencer for a 4096x64 dual-port RAM
module dpram_arbiter #(
  parameter bit FWD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [11:0] a_addr,
  input  logic [11:0] b_addr,
  input  logic [63:0] a_wdata,
  input  logic [63:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [63:0] a_rdata,
  output logic [63:0] b_rdata,
  output logic        ram_wr,
  output logic        ram_rd,
  output logic [11:0] ram_wr_add,
  output logic [11:0] ram_rd_add,
  output logic [63:0] ram_in,
  input  logic [63:0] ram_out,
  input  logic        stat_clr,
  output logic [15:0] conflict_cnt
);
  logic        wr_pri_q, wr_pri_d, rd_pri_q, rd_pri_d;
  logic        rd_pend_q, rd_pend_d, rd_tag_q, rd_tag_d;
  logic        fwd_q, fwd_d;
  logic [63:0] fwd_data_q, fwd_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        a_wc, b_wc, a_rc, b_rc, wr_b, rd_b;
  logic [1:0]  lost;
  logic [16:0] sum;
  logic [63:0] rd_data;

  assign a_wc = a_req & a_we;
  assign b_wc = b_req & b_we;
  assign a_rc = a_req & ~a_we;
  assign b_rc = b_req & ~b_we;
  assign wr_b = b_wc & (~a_wc | wr_pri_q);
  assign rd_b = b_rc & (~a_rc | rd_pri_q);

  assign a_gnt = rst_n & ((a_wc & ~wr_b) | (a_rc & ~rd_b));
  assign b_gnt = rst_n & ((b_wc & wr_b) | (b_rc & rd_b));

  assign ram_wr     = rst_n & (a_wc | b_wc);
  assign ram_rd     = rst_n & (a_rc | b_rc);
  assign ram_wr_add = ram_wr ? (wr_b ? b_addr : a_addr) : '0;
  assign ram_in     = ram_wr ? (wr_b ? b_wdata : a_wdata) : '0;
  assign ram_rd_add = ram_rd ? (rd_b ? b_addr : a_addr) : '0;

  assign lost = {1'b0, a_req & ~a_gnt} + {1'b0, b_req & ~b_gnt};
  assign sum  = {1'b0, cnt_q} + {15'b0, lost};

  // next state: priority flips to the loser on a grant, read tag/fwd capture the granted read
  always_comb begin
    wr_pri_d   = ram_wr ? ~wr_b : wr_pri_q;
    rd_pri_d   = ram_rd ? ~rd_b : rd_pri_q;
    rd_pend_d  = ram_rd;
    rd_tag_d   = ram_rd ? rd_b : rd_tag_q;
    fwd_d      = FWD && ram_wr && ram_rd && (ram_wr_add == ram_rd_add);
    fwd_data_d = fwd_d ? ram_in : fwd_data_q;
    cnt_d      = stat_clr ? '0 : (sum[16] ? 16'hFFFF : sum[15:0]);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pri_q   <= 1'b0;
      rd_pri_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      wr_pri_q   <= wr_pri_d;
      rd_pri_q   <= rd_pri_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_data      = fwd_q ? fwd_data_q : ram_out;
  assign a_rvalid     = rd_pend_q & ~rd_tag_q;
  assign b_rvalid     = rd_pend_q & rd_tag_q;
  assign a_rdata      = a_rvalid ? rd_data : '0;
  assign b_rdata      = b_rvalid ? rd_data : '0;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: scoreboard bench driving FWD=1 and FWD=0 instances with identical directed stimulus
module tb_dpram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, stat_clr = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [63:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, ram_wr1, ram_rd1;
  logic        a_gnt0, b_gnt0, a_rvalid0, b_rvalid0, ram_wr0, ram_rd0;
  logic [63:0] a_rdata1, b_rdata1, ram_in1, ram_out1;
  logic [63:0] a_rdata0, b_rdata0, ram_in0, ram_out0;
  logic [11:0] wa1, ra1, wa0, ra0;
  logic [15:0] cnt1, cnt0;
  logic [63:0] m1 [4096];
  logic [63:0] m0 [4096];
  logic        mon_on = 1'b0;
  int          total = 0, bad = 0;

  typedef struct {logic b; logic [63:0] d1; logic [63:0] d0;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  dpram_arbiter #(.FWD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt1), .b_gnt(b_gnt1), .a_rvalid(a_rvalid1), .b_rvalid(b_rvalid1),
    .a_rdata(a_rdata1), .b_rdata(b_rdata1), .ram_wr(ram_wr1), .ram_rd(ram_rd1),
    .ram_wr_add(wa1), .ram_rd_add(ra1), .ram_in(ram_in1), .ram_out(ram_out1),
    .stat_clr(stat_clr), .conflict_cnt(cnt1));

  dpram_arbiter #(.FWD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt0), .b_gnt(b_gnt0), .a_rvalid(a_rvalid0), .b_rvalid(b_rvalid0),
    .a_rdata(a_rdata0), .b_rdata(b_rdata0), .ram_wr(ram_wr0), .ram_rd(ram_rd0),
    .ram_wr_add(wa0), .ram_rd_add(ra0), .ram_in(ram_in0), .ram_out(ram_out0),
    .stat_clr(stat_clr), .conflict_cnt(cnt0));

  // behavioural RAMs: registered read returning old contents on a same-edge write
  initial begin
    for (int i = 0; i < 4096; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
    ram_out1 = '0;
    ram_out0 = '0;
  end

  always @(posedge clk) begin
    if (ram_wr1) m1[wa1] <= ram_in1;
    if (ram_rd1) ram_out1 <= m1[ra1];
    if (ram_wr0) m0[wa0] <= ram_in0;
    if (ram_rd0) ram_out0 <= m0[ra0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // one cycle of stimulus; grants checked mid-cycle, expected read data queued for the monitor
  task automatic cyc(input logic ar, input logic aw, input logic [11:0] aa, input logic [63:0] ad,
                     input logic br, input logic bw, input logic [11:0] ba, input logic [63:0] bd,
                     input logic eag, input logic ebg, input logic [63:0] e1, input logic [63:0] e0);
    @(posedge clk);
    #1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #3;
    chk("a_gnt1", a_gnt1, eag);
    chk("b_gnt1", b_gnt1, ebg);
    chk("a_gnt0", a_gnt0, eag);
    chk("b_gnt0", b_gnt0, ebg);
    if (eag && ar && !aw) q.push_back('{1'b0, e1, e0});
    if (ebg && br && !bw) q.push_back('{1'b1, e1, e0});
  endtask

  task automatic idle();
    cyc(0, 0, 12'h0, 64'h0, 0, 0, 12'h0, 64'h0, 0, 0, 64'h0, 64'h0);
  endtask

  // monitor: every cycle, pop the read due now or require both rvalids low
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("a_rvalid1", a_rvalid1, !e.b);
          chk("b_rvalid1", b_rvalid1, e.b);
          chk("rdata1", e.b ? b_rdata1 : a_rdata1, e.d1);
          chk("other_rdata1", e.b ? a_rdata1 : b_rdata1, 64'h0);
          chk("a_rvalid0", a_rvalid0, !e.b);
          chk("b_rvalid0", b_rvalid0, e.b);
          chk("rdata0", e.b ? b_rdata0 : a_rdata0, e.d0);
          chk("other_rdata0", e.b ? a_rdata0 : b_rdata0, 64'h0);
        end else begin
          chk("no_rvalid1", {a_rvalid1, b_rvalid1}, 64'h0);
          chk("no_rvalid0", {a_rvalid0, b_rvalid0}, 64'h0);
        end
      end
    end
  end

  initial begin
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_addr = 12'h001; b_addr = 12'h002;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #4;
      chk("rst_gnt1", {a_gnt1, b_gnt1}, 64'h0);
      chk("rst_gnt0", {a_gnt0, b_gnt0}, 64'h0);
      chk("rst_ram_en1", {ram_wr1, ram_rd1}, 64'h0);
      chk("rst_ram_en0", {ram_wr0, ram_rd0}, 64'h0);
    end
    chk("rst_rvalid", {a_rvalid1, b_rvalid1, a_rvalid0, b_rvalid0}, 64'h0);
    chk("rst_rdata1", a_rdata1 | b_rdata1, 64'h0);
    chk("rst_rdata0", a_rdata0 | b_rdata0, 64'h0);
    chk("rst_cnt1", cnt1, 64'h0);
    chk("rst_cnt0", cnt0, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1; a_req = 0; b_req = 0;
    mon_on = 1;
    // contested writes: A,B,A,B; the loser holds its operation
    cyc(1, 1, 12'h020, 64'hA1, 1, 1, 12'h021, 64'hB1, 1, 0, 64'h0, 64'h0);
    cyc(1, 1, 12'h020, 64'hA2, 1, 1, 12'h021, 64'hB1, 0, 1, 64'h0, 64'h0);
    cyc(1, 1, 12'h020, 64'hA2, 1, 1, 12'h021, 64'hB2, 1, 0, 64'h0, 64'h0);
    cyc(1, 1, 12'h020, 64'hA3, 1, 1, 12'h021, 64'hB2, 0, 1, 64'h0, 64'h0);
    idle();
    chk("cnt_contest1", cnt1, 64'd4);
    chk("cnt_contest0", cnt0, 64'd4);
    // contested reads, back to back
    cyc(1, 0, 12'h020, 64'h0, 1, 0, 12'h021, 64'h0, 1, 0, 64'hA2, 64'hA2);
    cyc(0, 0, 12'h000, 64'h0, 1, 0, 12'h021, 64'h0, 0, 1, 64'hB2, 64'hB2);
    // write then read
    cyc(1, 1, 12'h010, 64'h0123_4567_89AB_CDEF, 0, 0, 12'h0, 64'h0, 1, 0, 64'h0, 64'h0);
    cyc(1, 0, 12'h010, 64'h0, 0, 0, 12'h0, 64'h0, 1, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    // mixed ports, including address 0xFFF
    cyc(0, 0, 12'h0, 64'h0, 1, 1, 12'h000, 64'hDEAD_BEEF_0000_0001, 0, 1, 64'h0, 64'h0);
    cyc(1, 1, 12'hFFF, 64'hFFF0_0000_0000_0FFF, 1, 0, 12'h000, 64'h0, 1, 1,
        64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    cyc(1, 0, 12'hFFF, 64'h0, 0, 0, 12'h0, 64'h0, 1, 0, 64'hFFF0_0000_0000_0FFF, 64'hFFF0_0000_0000_0FFF);
    // same-cycle collision: forwarded on FWD=1, old contents on FWD=0
    cyc(0, 0, 12'h0, 64'h0, 1, 1, 12'h055, 64'h11, 0, 1, 64'h0, 64'h0);
    cyc(1, 1, 12'h055, 64'h22, 1, 0, 12'h055, 64'h0, 1, 1, 64'h22, 64'h11);
    cyc(0, 0, 12'h0, 64'h0, 1, 0, 12'h055, 64'h0, 0, 1, 64'h22, 64'h22);
    idle();
    chk("cnt_mid1", cnt1, 64'd5);
    chk("cnt_mid0", cnt0, 64'd5);
    // saturation under sustained contention, then clear with contention still present
    @(posedge clk);
    #1;
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_addr = 12'h100; b_addr = 12'h101;
    repeat (70000) @(posedge clk);
    #3;
    chk("cnt_sat1", cnt1, 64'hFFFF);
    chk("cnt_sat0", cnt0, 64'hFFFF);
    stat_clr = 1;
    @(posedge clk);
    #1;
    stat_clr = 0; a_req = 0; b_req = 0;
    #3;
    chk("cnt_clr1", cnt1, 64'h0);
    chk("cnt_clr0", cnt0, 64'h0);
    idle();
    chk("cnt_hold1", cnt1, 64'h0);
    idle();
    chk("queue_empty", q.size(), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Two-requester arbiter and sequencer for the 4096 x 64 dual-port RAM. It shares the RAM's write port and read port between requesters A and B with independent round-robin arbitration per port. It returns read data to the requester that issued the read, and forwards write data when a read and a write hit the same address in the same cycle. It sits directly in front of the RAM. Its RAM-side ports connect one-to-one to the RAM's clk/wr/rd/wr_add/rd_add/in/out.

## Interface
- FWD, 1: 1 = same-cycle read/write address collision returns the new write data; 0 = returns old RAM contents
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- a_req, b_req  in  1  requester has an operation pending
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  12  word address
- a_wdata, b_wdata  in  64  write data
- a_gnt, b_gnt  out  1  combinational; the operation is accepted this cycle when req & gnt
- a_rvalid, b_rvalid  out  1  read data valid (registered)
- a_rdata, b_rdata  out  64  read data, 0 when the matching rvalid is 0
- ram_wr, ram_rd  out  1  RAM write/read enables
- ram_wr_add, ram_rd_add  out  12  RAM addresses
- ram_in  out  64  RAM write data
- ram_out  in  64  RAM read data (registered in RAM, 1-cycle latency)
- stat_clr  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  16  saturating count of lost-arbitration cycles

## Operation
- A requester presents one operation per cycle. req, we, addr and wdata stay stable until gnt.
- Write port: candidates are the requesters with req & we.
  - One candidate: it is granted.
  - Two candidates: wr_pri decides (0 = A, 1 = B).
  - After any write grant, wr_pri points to the non-winning requester.
- Read port: same rule among requesters with req & !we, using rd_pri.
- The ports are independent. A write by A and a read by B, or the reverse, are both granted in the same cycle.
- RAM drive for a granted write: ram_wr=1, ram_wr_add/ram_in from the winner.
- RAM drive for a granted read: ram_rd=1, ram_rd_add from the winner.
- RAM drive when a port is idle: enable 0, address and data 0.
- Read return: a 1-bit tag registers the read winner (rd_tag) and a flag registers that a read was granted (rd_pend).
  - Next cycle, rvalid is asserted for the tagged requester only.
  - The tagged requester's rdata = ram_out, or the forward register on a collision.
- Collision, FWD=1: a read and a write granted in the same cycle with equal addresses.
  - wdata is registered together with a flag.
  - Next cycle, rdata = the registered write data instead of ram_out.
- Collision, FWD=0: rdata = ram_out, which is the old contents.
- conflict_cnt: +1 for each requester that has req=1 and gnt=0 in a cycle, so +2 is possible.
  - Saturates at 0xFFFF.
  - stat_clr has priority over increment.
- While rst_n=0: a_gnt, b_gnt, ram_wr and ram_rd are forced 0 combinationally.

## Timing
- Reset state, reached at the rising edge with rst_n=0:
  - wr_pri=0, rd_pri=0
  - rd_pend=0, rd_tag=0, fwd flag=0, fwd register=0
  - conflict_cnt=0
  - a_rvalid=b_rvalid=0 and a_rdata=b_rdata=0 from the first cycle after that edge
- Grant latency: 0 cycles (combinational from req).
- Write completion: the RAM is updated at the edge ending the grant cycle.
- Read latency: grant in cycle N gives rvalid and rdata in cycle N+1, for exactly one cycle.
- Reads are pipelined, so back-to-back reads give back-to-back rvalid.
- A write granted at cycle N is visible to a read granted at cycle N+1 or later, regardless of FWD.
- Reset mid-operation: if rst_n=0 at the edge following a read grant, the read is dropped (no rvalid). Writes granted in the cycle before a reset edge still complete.
- Address wrap: 12-bit addresses, no arithmetic, no wrap logic. 0xFFF is a legal address.
- A requester whose req drops before gnt loses nothing. Arbitration state changes only on a grant.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with a_req=b_req=1. Required: no gnt, ram_wr=ram_rd=0, all outputs 0. After release, A wins the first contested write.
- Write then read: A writes 0x0123_4567_89AB_CDEF to 0x010, then A reads 0x010. Required: a_rvalid one cycle after the read grant with that data, and b_rvalid=0.
- Contested writes: A and B both hold writes for 4 cycles to 0x020 and 0x021 respectively, with new data each cycle. Required: grants A,B,A,B, and conflict_cnt increments by 1 per cycle, reaching 4.
- Mixed ports: in one cycle A writes 0xFFF and B reads 0x000. Required: both granted, and b_rvalid next cycle with the contents of 0x000.
- Collision: 0x055 holds 0x11. In the same cycle A writes 0x22 to 0x055 and B reads 0x055. Required: FWD=1 gives b_rdata=0x22; FWD=0 gives 0x11.
- Saturation and clear: force 70000 cycles of contention. Required: conflict_cnt holds 0xFFFF. Then one cycle of stat_clr=1 gives conflict_cnt=0 on the following cycle.
